screen_painter: RTL

SCREEN_PAINTER -- requirements
Module: screen_painter

---
 rtl/screen_painter_pkg.sv | 29 ++
 rtl/screen_painter_if.sv | 21 ++
 rtl/screen_painter_pixel_scan.sv | 42 ++++
 rtl/screen_painter.sv | 116 +++++++++++
 4 files changed

// File: rtl/screen_painter_pkg.sv
// Shared types and constants for the screen painter: frame geometry, mode and state encodings, colours.
package screen_painter_pkg;

   localparam int unsigned DEF_WIDTH  = 160;
   localparam int unsigned DEF_HEIGHT = 120;
   localparam int unsigned LAST_PIXEL = DEF_WIDTH * DEF_HEIGHT - 1;
   localparam int unsigned ADDR_W     = 15;
   localparam int unsigned X_W        = 8;
   localparam int unsigned Y_W        = 7;
   localparam int unsigned COLOUR_W   = 3;

   typedef enum logic [1:0] {MODE_BLACK, MODE_TITLE, MODE_OVER, MODE_FLASH} mode_e;
   typedef enum logic [1:0] {S_IDLE, S_PAINT, S_DRAIN, S_HOLD} state_e;

   localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
   localparam logic [COLOUR_W-1:0] COLOUR_RED   = 3'b100;
   localparam logic [COLOUR_W-1:0] COLOUR_WHITE = 3'b111;

   // Frame source priority: title > game-over > flash > black.
   function automatic mode_e pick_mode(input logic title, input logic over,
                                       input logic flash, input logic black);
      if (title)      return MODE_TITLE;
      else if (over)  return MODE_OVER;
      else if (flash) return MODE_FLASH;
      else if (black) return MODE_BLACK;
      else            return MODE_BLACK;
   endfunction

endpackage

// File: rtl/screen_painter_if.sv
// Sequencer/ROM/VGA-adapter signal bundle for the screen painter.
interface screen_painter_if;
   logic        wren;
   logic        showTitle;
   logic        showGameOver;
   logic        flash;
   logic        drawBlack;
   logic [2:0]  titleData;
   logic [2:0]  overData;
   logic [14:0] romAddr;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;
   logic        done;

   modport master (output wren, showTitle, showGameOver, flash, drawBlack, titleData, overData,
                   input  romAddr, x, y, colour, plot, done);
   modport slave  (input  wren, showTitle, showGameOver, flash, drawBlack, titleData, overData,
                   output romAddr, x, y, colour, plot, done);
endinterface

// File: rtl/screen_painter_pixel_scan.sv
// Raster scan counters: x/y coordinate and running linear ROM address, advanced one pixel per enable.
module pixel_scan
   import screen_painter_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned HEIGHT = DEF_HEIGHT,
   parameter int unsigned LAST   = LAST_PIXEL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              enable,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic [ADDR_W-1:0] addr,
   output logic              last_c
);

   assign last_c = (addr == ADDR_W'(LAST));

   // Address runs alongside x/y so no y*WIDTH multiply is needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (clear) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (enable) begin
         addr <= addr + ADDR_W'(1);
         if (x == X_W'(WIDTH - 1)) begin
            x <= '0;
            y <= y + Y_W'(1);
         end else begin
            x <= x + X_W'(1);
         end
      end
   end

endmodule

// File: rtl/screen_painter.sv
// Paints one full frame from the title ROM, game-over ROM, flash or black into the VGA adapter.
// Optional SCREEN_PAINTER_BORDER_EN: flash frames get a white one-pixel border.
module screen_painter
   import screen_painter_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned HEIGHT = DEF_HEIGHT
) (
   input logic             clk,
   input logic             rst,
   screen_painter_if.slave bus
);

   state_e              state;
   mode_e               mode_q;
   logic [X_W-1:0]      x_q;
   logic [Y_W-1:0]      y_q;
   logic                plot_q;
   logic                done_q;
   logic [X_W-1:0]      scan_x;
   logic [Y_W-1:0]      scan_y;
   logic [ADDR_W-1:0]   scan_addr;
   logic                scan_last_c;
   logic                scan_clear_c;
   logic                scan_enable_c;
   logic [COLOUR_W-1:0] colour_c;

   assign scan_clear_c  = (state == S_IDLE) && bus.wren;
   assign scan_enable_c = (state == S_PAINT) && bus.wren && !scan_last_c;

   pixel_scan #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .LAST   (WIDTH * HEIGHT - 1)
   ) u_scan (
      .clk    (clk),
      .rst    (rst),
      .clear  (scan_clear_c),
      .enable (scan_enable_c),
      .x      (scan_x),
      .y      (scan_y),
      .addr   (scan_addr),
      .last_c (scan_last_c)
   );

   // Frame sequencer; x/y/plot/done trail the issued address by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         mode_q <= MODE_BLACK;
         x_q    <= '0;
         y_q    <= '0;
         plot_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         plot_q <= 1'b0;
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.wren) begin
                  mode_q <= pick_mode(bus.showTitle, bus.showGameOver, bus.flash, bus.drawBlack);
                  x_q    <= '0;
                  y_q    <= '0;
                  state  <= S_PAINT;
               end
            end
            S_PAINT: begin
               if (!bus.wren) begin
                  state <= S_IDLE;
               end else begin
                  plot_q <= 1'b1;
                  x_q    <= scan_x;
                  y_q    <= scan_y;
                  if (scan_last_c) begin
                     done_q <= 1'b1;
                     state  <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: state <= S_HOLD;
            S_HOLD: begin
               if (!bus.wren) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ROM data arrives one cycle after the address, aligned with x_q/y_q, so the mux is combinational.
   always_comb begin
      colour_c = COLOUR_BLACK;
      case (mode_q)
         MODE_TITLE: colour_c = bus.titleData;
         MODE_OVER:  colour_c = bus.overData;
         MODE_FLASH: begin
`ifdef SCREEN_PAINTER_BORDER_EN
            if (x_q == '0 || x_q == X_W'(WIDTH - 1) || y_q == '0 || y_q == Y_W'(HEIGHT - 1))
               colour_c = COLOUR_WHITE;
            else
               colour_c = COLOUR_RED;
`else
            colour_c = COLOUR_RED;
`endif
         end
         default: colour_c = COLOUR_BLACK;
      endcase
   end

   assign bus.romAddr = scan_addr;
   assign bus.x       = x_q;
   assign bus.y       = y_q;
   assign bus.plot    = plot_q;
   assign bus.done    = done_q;
   assign bus.colour  = colour_c;

endmodule
